pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Parametrised pipeline hazard controller for the 5-stage CPU; generalises the fixed 6-bit stall controller.
//   Merges per-stage stall requests into a thermometer stall bus.
//   Sequences multi-cycle flushes with a redirect PC.
//   Runs a stall watchdog. Sits beside the pipeline; drives all stage-register enables and the PC mux.
// PARAMETERS
//   NSTAGE      6   width of stall bus / request vector (bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB)
//   PC_W        32  redirect PC width
//   FLUSH_CYC   1   cycles flush stays asserted per event (>=1)
//   TIMEOUT     64  consecutive stalled cycles before stall_timeout sets; 0 disables watchdog
// PORTS
//   clk            in   1        clock, rising edge
//   rst            in   1        reset, synchronous, active-high
//   stallreq       in   NSTAGE   bit i: stage i requests hold of stages 0..i
//   flush_req      in   1        single-cycle redirect request (exception/branch fixup)
//   flush_pc       in   PC_W     target PC, sampled when flush_req=1
//   stall          out  NSTAGE   hold enables, thermometer-coded (combinational)
//   flush          out  1        registered flush pulse to all stage registers
//   new_pc         out  PC_W     registered redirect PC, valid while flush=1
//   stall_timeout  out  1        sticky watchdog flag
//   stall_cnt      out  32       perf: total stalled cycles
//   flush_cnt      out  16       perf: total flush events
// BEHAVIOUR
//   Reset: stall=0, flush=0, new_pc=0, stall_timeout=0, counters=0, FSM=IDLE; applies on the edge rst is high.
//     stall is forced 0 combinationally while rst=1.
//   Stall: h = highest set index of stallreq; stall[k]=1 for k<=h, else 0; stallreq=0 -> stall=0.
//     Example: stallreq=6'b001000 -> stall=6'b001111.
//   Stall suppression: stall=0 whenever flush_req=1 or FSM=FLUSH.
//   FSM IDLE: flush_req=1 -> next edge FLUSH, flush=1, new_pc<=flush_pc, cnt<=FLUSH_CYC-1.
//   FSM FLUSH: cnt!=0 -> cnt--, flush stays 1.
//     cnt==0 and flush_req=0 -> IDLE; flush=0 at that edge.
//     flush_req=1 in any FLUSH cycle -> restart: new_pc<=flush_pc, cnt<=FLUSH_CYC-1, stay FLUSH.
//     Latest request wins.
//   Latency: flush_req to flush = 1 cycle; flush width = FLUSH_CYC cycles absent re-requests.
//   Watchdog: wd counter increments each cycle stall!=0 (saturating) and clears on any cycle stall==0.
//     Sets stall_timeout when it reaches TIMEOUT.
//     stall_timeout is cleared only by rst. Width $clog2(TIMEOUT+1). TIMEOUT=0 -> stall_timeout tied 0.
//   Reset mid-flush: FSM->IDLE, flush=0, pending cnt discarded.
// CONFIGURATION
//   PIPE_HAZARD_CTRL_PERF_EN defined:
//     stall_cnt +1 every cycle stall!=0; wraps 2^32-1 -> 0.
//     flush_cnt +1 on each IDLE->FLUSH or restart edge; wraps 16'hFFFF -> 0.
//   Undefined: stall_cnt and flush_cnt tied 0, no counter flops; ports remain present.
// TESTING
//   stallreq=6'b000100 then 6'b001100 -> stall=6'b000111 then 6'b001111; stallreq=0 -> stall=0.
//   FLUSH_CYC=2, flush_req=1 with flush_pc=32'h0000_3000 at cycle t:
//     flush=1 at t+1 and t+2, new_pc=32'h3000, flush=0 at t+3.
//     stallreq=6'b001111 held throughout -> stall=0 over t..t+2.
//   flush_req with pc 32'hA0 at t, then pc 32'hB0 at t+1 -> new_pc=32'hB0 from t+2.
//     flush stays high until FLUSH_CYC cycles after t+1.
//   TIMEOUT=4, stallreq=6'b000011 held 4 cycles:
//     stall_timeout=1 after 4th stalled edge and stays 1 after stallreq=0; drops only after rst.
//   TIMEOUT=4, 3 stalled cycles, 1 free cycle, 3 stalled -> stall_timeout stays 0.
//   rst=1 during FLUSH (FLUSH_CYC=4, cycle 2) -> next edge flush=0, new_pc=0, counters=0.
//     Perf build: preloaded stall_cnt=32'hFFFF_FFFF plus one stalled cycle -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for the 5-stage CPU. It sits beside the pipeline and drives
//   every stage-register enable and the PC mux.
//   - It merges per-stage stall requests into a thermometer-coded stall bus.
//   - It sequences flushes that last several cycles and carry a redirect PC.
//   - It runs a stall watchdog with a sticky timeout flag.
//
// Parameters
//   NSTAGE    : width of the stall bus (bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB)
//   PC_W      : width of the redirect PC
//   FLUSH_CYC : number of cycles flush stays high for each event (>=1)
//   TIMEOUT   : number of consecutive stalled cycles before stall_timeout sets (0 = off)
//
// Ports
//   clk, rst       : clock (rising edge) and synchronous active-high reset
//   stallreq       : bit i set means stage i requests a hold of stages 0..i
//   flush_req      : single-cycle redirect request; flush_pc is sampled with it
//   stall          : combinational thermometer hold enables
//   flush, new_pc  : registered flush pulse and registered redirect PC
//   stall_timeout  : sticky watchdog flag, cleared only by rst
//   stall_cnt      : count of stalled cycles (perf build only)
//   flush_cnt      : count of flush events (perf build only)
//
// Configuration macro
//   PIPE_HAZARD_CTRL_PERF_EN enables the performance counters.
//   When it is undefined, stall_cnt and flush_cnt are tied to 0.
//
// Handshake: the controller has no valid/ready channel. A flush_req is always
//   accepted on the edge where it is high, in either FSM state. The latest
//   request wins.
module pipe_hazard_ctrl #(
  parameter int NSTAGE    = 6,
  parameter int PC_W      = 32,
  parameter int FLUSH_CYC = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              flush_req,
  input  logic [PC_W-1:0]   flush_pc,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic              stall_timeout,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t            state_q;
  logic              flush_q;
  logic [PC_W-1:0]   new_pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NSTAGE-1:0] therm;
  logic              seen;
  logic              stall_any;

  // Scanning from the top stage down, every stage at or below the highest
  // requester is held.
  always_comb begin
    therm = '0;
    seen  = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      seen     = seen | stallreq[i];
      therm[i] = seen;
    end
  end

  // A redirect in flight overrides holds; a held stage would otherwise keep
  // the wrong-path instruction that the flush is meant to kill.
  assign stall     = (rst || flush_req || (state_q == FLUSH)) ? '0 : therm;
  assign stall_any = |stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q  <= FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= flush_pc;
            cnt_q    <= CNT_W'(FLUSH_CYC - 1);
          end
        end
        FLUSH: begin
          if (flush_req) begin
            // Restart: the new target replaces the old one and the full
            // width begins again.
            new_pc_q <= flush_pc;
            cnt_q    <= CNT_W'(FLUSH_CYC - 1);
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush  = flush_q;
  assign new_pc = new_pc_q;

  generate
    if (TIMEOUT == 0) begin : g_no_wd
      assign stall_timeout = 1'b0;
    end else begin : g_wd
      localparam int WD_W = $clog2(TIMEOUT + 1);
      logic [WD_W-1:0] wd_q;
      logic [WD_W-1:0] wd_d;
      logic            to_q;

      // The count saturates at TIMEOUT and clears on any cycle with no stall.
      always_comb begin
        wd_d = '0;
        if (stall_any) begin
          wd_d = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wd_q <= '0;
          to_q <= 1'b0;
        end else begin
          wd_q <= wd_d;
          if (wd_d == WD_W'(TIMEOUT)) begin
            to_q <= 1'b1;
          end
        end
      end

      assign stall_timeout = to_q;
    end
  endgenerate

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Both counters wrap naturally. Every flush_req starts or restarts a
  // flush, so each one counts as an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_any) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_req) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
